// File: rtl/hit_pkg.sv
// Shared state encoding and default tuning constants for the hit tracker.
// Also supplies the post-stun invulnerability default (HIT_TRACKER_POSTSTUN_INVULN_EN builds).
package hit_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    STUN   = 2'd1,
    INVULN = 2'd2
  } hit_state_e;

  localparam int DEF_MAX_DAMAGE      = 999;
  localparam int DEF_BASE_HITSTUN    = 20;
  localparam int DEF_HITSTUN_SHIFT   = 4;
  localparam int DEF_RESPAWN_INVULN  = 60;
  localparam int DEF_POSTSTUN_INVULN = 10;

endpackage

// File: rtl/hit_channel.sv
// One fighter: damage accumulator, hitstun and invulnerability countdown.
// Optional macro HIT_TRACKER_POSTSTUN_INVULN_EN sends STUN expiry into INVULN.
module hit_channel import hit_pkg::*; #(
  parameter int DMG_W          = 10,
  parameter int MAX_DAMAGE     = DEF_MAX_DAMAGE,
  parameter int HIT_W          = 6,
  parameter int STUN_W         = 8,
  parameter int BASE_HITSTUN   = DEF_BASE_HITSTUN,
  parameter int HITSTUN_SHIFT  = DEF_HITSTUN_SHIFT,
  parameter int RESPAWN_INVULN = DEF_RESPAWN_INVULN
`ifdef HIT_TRACKER_POSTSTUN_INVULN_EN
  , parameter int POSTSTUN_INVULN = DEF_POSTSTUN_INVULN
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             got_hit,
  input  logic [HIT_W-1:0] hit_damage_in,
  input  logic             respawn,
  output logic [DMG_W-1:0] damage,
  output logic             hit_stun_active,
  output logic             invuln_active,
  output logic             hit_accepted
);

  localparam int LEN_W = ((DMG_W > STUN_W) ? DMG_W : STUN_W) + 1;
  localparam logic [STUN_W-1:0] STUN_MAX = {STUN_W{1'b1}};
`ifdef HIT_TRACKER_POSTSTUN_INVULN_EN
  localparam int POST_FRAMES = POSTSTUN_INVULN;
`else
  localparam int POST_FRAMES = 0;
`endif

  hit_state_e         state_q, state_d;
  logic [STUN_W-1:0]  cnt_q, cnt_d;
  logic [DMG_W-1:0]   dmg_q, dmg_d;
  logic               acc_q, acc_d;
  logic               stun_q, inv_q;

  logic [DMG_W:0]     sum;
  logic [DMG_W-1:0]   new_dmg;
  logic [LEN_W-1:0]   len_wide;
  logic [STUN_W-1:0]  stun_len;

  // Saturating damage and damage-scaled hitstun length for a prospective hit.
  always_comb begin
    sum = {1'b0, dmg_q} + (DMG_W+1)'(hit_damage_in);
    if (sum > (DMG_W+1)'(MAX_DAMAGE)) begin
      new_dmg = DMG_W'(MAX_DAMAGE);
    end else begin
      new_dmg = sum[DMG_W-1:0];
    end
    len_wide = LEN_W'(BASE_HITSTUN) + LEN_W'(new_dmg >> HITSTUN_SHIFT);
    if (len_wide > LEN_W'(STUN_MAX)) begin
      stun_len = STUN_MAX;
    end else begin
      stun_len = len_wide[STUN_W-1:0];
    end
  end

  // Next state: respawn beats a hit, a hit beats the frame countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dmg_d   = dmg_q;
    acc_d   = 1'b0;
    if (respawn) begin
      dmg_d = '0;
      if (RESPAWN_INVULN > 0) begin
        state_d = INVULN;
        cnt_d   = STUN_W'(RESPAWN_INVULN);
      end else begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    end else if (got_hit && (state_q != INVULN)) begin
      dmg_d   = new_dmg;
      cnt_d   = stun_len;
      state_d = STUN;
      acc_d   = 1'b1;
    end else if (frame_tick) begin
      case (state_q)
        STUN: begin
          if (cnt_q > STUN_W'(1)) begin
            cnt_d = cnt_q - STUN_W'(1);
          end else if (POST_FRAMES > 0) begin
            state_d = INVULN;
            cnt_d   = STUN_W'(POST_FRAMES);
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        INVULN: begin
          if (cnt_q > STUN_W'(1)) begin
            cnt_d = cnt_q - STUN_W'(1);
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter, damage and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      dmg_q   <= '0;
      acc_q   <= 1'b0;
      stun_q  <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dmg_q   <= dmg_d;
      acc_q   <= acc_d;
      stun_q  <= (state_d == STUN);
      inv_q   <= (state_d == INVULN);
    end
  end

  assign damage          = dmg_q;
  assign hit_stun_active = stun_q;
  assign invuln_active   = inv_q;
  assign hit_accepted    = acc_q;

endmodule

// File: rtl/hit_tracker.sv
// NUM_PLAYERS independent hit/damage channels behind packed per-player port vectors.
// Optional macro HIT_TRACKER_POSTSTUN_INVULN_EN adds the POSTSTUN_INVULN parameter.
module hit_tracker import hit_pkg::*; #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DMG_W          = 10,
  parameter int MAX_DAMAGE     = DEF_MAX_DAMAGE,
  parameter int HIT_W          = 6,
  parameter int STUN_W         = 8,
  parameter int BASE_HITSTUN   = DEF_BASE_HITSTUN,
  parameter int HITSTUN_SHIFT  = DEF_HITSTUN_SHIFT,
  parameter int RESPAWN_INVULN = DEF_RESPAWN_INVULN
`ifdef HIT_TRACKER_POSTSTUN_INVULN_EN
  , parameter int POSTSTUN_INVULN = DEF_POSTSTUN_INVULN
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               frame_tick,
  input  logic [NUM_PLAYERS-1:0]             got_hit,
  input  logic [NUM_PLAYERS-1:0][HIT_W-1:0]  hit_damage_in,
  input  logic [NUM_PLAYERS-1:0]             respawn,
  output logic [NUM_PLAYERS-1:0][DMG_W-1:0]  damage,
  output logic [NUM_PLAYERS-1:0]             hit_stun_active,
  output logic [NUM_PLAYERS-1:0]             invuln_active,
  output logic [NUM_PLAYERS-1:0]             hit_accepted
);

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_ch
    hit_channel #(
      .DMG_W          (DMG_W),
      .MAX_DAMAGE     (MAX_DAMAGE),
      .HIT_W          (HIT_W),
      .STUN_W         (STUN_W),
      .BASE_HITSTUN   (BASE_HITSTUN),
      .HITSTUN_SHIFT  (HITSTUN_SHIFT),
      .RESPAWN_INVULN (RESPAWN_INVULN)
`ifdef HIT_TRACKER_POSTSTUN_INVULN_EN
      , .POSTSTUN_INVULN (POSTSTUN_INVULN)
`endif
    ) u_ch (
      .clk             (clk),
      .reset           (reset),
      .frame_tick      (frame_tick),
      .got_hit         (got_hit[p]),
      .hit_damage_in   (hit_damage_in[p]),
      .respawn         (respawn[p]),
      .damage          (damage[p]),
      .hit_stun_active (hit_stun_active[p]),
      .invuln_active   (invuln_active[p]),
      .hit_accepted    (hit_accepted[p])
    );
  end

endmodule

// File: tb/tb_hit_tracker.sv
// Self-checking bench for hit_tracker: directed scenarios plus random traffic,
// every cycle compared against a frames-remaining reference model.
module tb_hit_tracker;

  localparam int NP = 2;
`ifdef HIT_TRACKER_POSTSTUN_INVULN_EN
  localparam int POST = 10;
`else
  localparam int POST = 0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 frame_tick;
  logic [NP-1:0]        got_hit;
  logic [NP-1:0][5:0]   hit_damage_in;
  logic [NP-1:0]        respawn;
  logic [NP-1:0][9:0]   damage;
  logic [NP-1:0]        hit_stun_active;
  logic [NP-1:0]        invuln_active;
  logic [NP-1:0]        hit_accepted;

  int checks = 0;
  int errors = 0;
  int m_dmg[NP];
  int m_stun[NP];
  int m_inv[NP];
  int m_acc[NP];
  int n;

  hit_tracker dut (
    .clk             (clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .got_hit         (got_hit),
    .hit_damage_in   (hit_damage_in),
    .respawn         (respawn),
    .damage          (damage),
    .hit_stun_active (hit_stun_active),
    .invuln_active   (invuln_active),
    .hit_accepted    (hit_accepted)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Model tracks frames left in stun / invulnerability rather than an FSM state.
  task automatic model_step();
    for (int p = 0; p < NP; p++) begin
      if (reset) begin
        m_dmg[p] = 0; m_stun[p] = 0; m_inv[p] = 0; m_acc[p] = 0;
      end else if (respawn[p]) begin
        m_dmg[p] = 0; m_stun[p] = 0; m_inv[p] = 60; m_acc[p] = 0;
      end else if (got_hit[p] && m_inv[p] == 0) begin
        m_dmg[p] = m_dmg[p] + int'(hit_damage_in[p]);
        if (m_dmg[p] > 999) m_dmg[p] = 999;
        m_stun[p] = 20 + m_dmg[p] / 16;
        if (m_stun[p] > 255) m_stun[p] = 255;
        m_acc[p] = 1;
      end else begin
        m_acc[p] = 0;
        if (frame_tick) begin
          if (m_stun[p] > 0) begin
            m_stun[p]--;
            if (m_stun[p] == 0) m_inv[p] = POST;
          end else if (m_inv[p] > 0) begin
            m_inv[p]--;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    for (int p = 0; p < NP; p++) begin
      check_val($sformatf("dmg%0d", p),  damage[p],          m_dmg[p]);
      check_val($sformatf("stun%0d", p), hit_stun_active[p], m_stun[p] > 0);
      check_val($sformatf("inv%0d", p),  invuln_active[p],   m_inv[p] > 0);
      check_val($sformatf("acc%0d", p),  hit_accepted[p],    m_acc[p]);
    end
  endtask

  task automatic cyc(input logic tk, input logic [1:0] h, input logic [5:0] d0,
                     input logic [5:0] d1, input logic [1:0] r, input logic rs);
    frame_tick = tk; got_hit = h; hit_damage_in[0] = d0; hit_damage_in[1] = d1;
    respawn = r; reset = rs;
    step();
  endtask

  initial begin
    cyc(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
    cyc(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
    check_val("rst_dmg", damage, 0);
    check_val("rst_flags", {hit_stun_active, invuln_active, hit_accepted}, 0);

    // First hit of 12: 20-frame stun, player 1 untouched.
    cyc(1'b0, 2'b01, 6'd12, 6'd0, 2'b00, 1'b0);
    check_val("t1_dmg", damage[0], 12);
    check_val("t1_acc", hit_accepted, 2'b01);
    check_val("t1_stun", hit_stun_active, 2'b01);
    cyc(1'b0, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    check_val("t1_acc_pulse", hit_accepted[0], 0);
    n = 0;
    while (hit_stun_active[0] && n < 300) begin
      cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      n++;
    end
    check_val("t1_stun_len", n, 20);
    check_val("t1_post_inv", invuln_active[0], POST > 0);
    n = 0;
    while (invuln_active[0] && n < 300) begin
      cyc(1'b1, 2'b01, 6'd7, 6'd0, 2'b00, 1'b0);
      n++;
    end
    check_val("t1_post_len", n, POST);
    check_val("t1_post_dmg", damage[0], 12);

    // Build to 100, then 115 (27 frames), re-hit with a tick at frame 10.
    cyc(1'b0, 2'b01, 6'd44, 6'd0, 2'b00, 1'b0);
    cyc(1'b0, 2'b01, 6'd44, 6'd0, 2'b00, 1'b0);
    check_val("t2_pre", damage[0], 100);
    cyc(1'b0, 2'b01, 6'd15, 6'd0, 2'b00, 1'b0);
    check_val("t2_dmg", damage[0], 115);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    cyc(1'b1, 2'b01, 6'd5, 6'd0, 2'b00, 1'b0);
    check_val("t2_dmg2", damage[0], 120);
    n = 0;
    while (hit_stun_active[0] && n < 300) begin
      cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      n++;
    end
    check_val("t2_stun_len", n, 27);
    for (int i = 0; i < POST; i++) cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);

    // Respawn player 1; hits during invulnerability are ignored.
    cyc(1'b0, 2'b10, 6'd0, 6'd9, 2'b00, 1'b0);
    cyc(1'b0, 2'b00, 6'd0, 6'd0, 2'b10, 1'b0);
    check_val("t3_dmg1", damage[1], 0);
    check_val("t3_inv1", invuln_active[1], 1);
    cyc(1'b0, 2'b10, 6'd0, 6'd30, 2'b00, 1'b0);
    check_val("t3_ign_acc", hit_accepted[1], 0);
    check_val("t3_ign_dmg", damage[1], 0);
    n = 0;
    while (invuln_active[1] && n < 300) begin
      cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      n++;
    end
    check_val("t3_inv_len", n, 60);

    // Respawn beats a same-cycle hit.
    cyc(1'b0, 2'b01, 6'd20, 6'd0, 2'b01, 1'b0);
    check_val("t4_acc", hit_accepted[0], 0);
    check_val("t4_dmg", damage[0], 0);
    for (int i = 0; i < 60; i++) cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);

    // Drive to 995, then saturate at 999 with an 82-frame stun.
    for (int i = 0; i < 15; i++) cyc(1'b0, 2'b01, 6'd63, 6'd0, 2'b00, 1'b0);
    cyc(1'b0, 2'b01, 6'd50, 6'd0, 2'b00, 1'b0);
    check_val("t5_pre", damage[0], 995);
    cyc(1'b0, 2'b01, 6'd12, 6'd0, 2'b00, 1'b0);
    check_val("t5_sat", damage[0], 999);
    n = 0;
    while (hit_stun_active[0] && n < 300) begin
      cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
      n++;
    end
    check_val("t5_stun_len", n, 82);

    // Zero-damage hit, then reset mid-stun.
    cyc(1'b0, 2'b11, 6'd0, 6'd3, 2'b00, 1'b0);
    check_val("t6_zero_dmg", damage[0], 999);
    check_val("t6_zero_stun", hit_stun_active[0], 1);
    cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b0);
    cyc(1'b1, 2'b00, 6'd0, 6'd0, 2'b00, 1'b1);
    check_val("t6_rst", {damage, hit_stun_active, invuln_active, hit_accepted}, 0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 1) == 0),
          {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)},
          6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
          {($urandom_range(0, 79) == 0), ($urandom_range(0, 79) == 0)},
          ($urandom_range(0, 399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hit_tracker.md
Name: hit_tracker

Overview:
- Parametrised successor to the single-player hit/damage FSM.
- Tracks accumulated damage, hitstun and respawn invulnerability for NUM_PLAYERS independent fighters.
- Hitstun length scales with post-hit damage.
- Sits between the hitbox-collision logic, which supplies got_hit and damage per player, and the player movement/animation FSMs and the HUD damage readout.

Parameters:
- NUM_PLAYERS, 2: number of independent player channels.
- DMG_W, 10: damage register width.
- MAX_DAMAGE, 999: damage saturation ceiling; must be < 2**DMG_W.
- HIT_W, 6: width of the per-hit damage input.
- STUN_W, 8: frame-counter width for hitstun and invulnerability.
- BASE_HITSTUN, 20: base hitstun frames per accepted hit.
- HITSTUN_SHIFT, 4: extra hitstun equals post-hit damage >> HITSTUN_SHIFT.
- RESPAWN_INVULN, 60: invulnerability frames after respawn; 0 means respawn goes straight to ACTIVE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- got_hit  in  NUM_PLAYERS  per-player hit strobe.
- hit_damage_in  in  NUM_PLAYERS x HIT_W  damage for this hit, valid with got_hit.
- respawn  in  NUM_PLAYERS  per-player respawn strobe.
- damage  out  NUM_PLAYERS x DMG_W  accumulated damage.
- hit_stun_active  out  NUM_PLAYERS  player is in STUN.
- invuln_active  out  NUM_PLAYERS  player is in INVULN.
- hit_accepted  out  NUM_PLAYERS  one-cycle pulse: a hit was applied.

Behaviour:
- Channels are fully independent; each has state {ACTIVE, STUN, INVULN}, a STUN_W counter and a DMG_W damage register. All outputs are registered.
- Reset: state ACTIVE, counter 0, damage 0, all outputs 0.
- Priority per channel, per cycle: reset > respawn > got_hit > frame_tick countdown.
- respawn:
  - damage <= 0; hit_accepted stays 0.
  - If RESPAWN_INVULN > 0: state INVULN, counter <= RESPAWN_INVULN.
  - Otherwise: state ACTIVE, counter <= 0.
- got_hit in ACTIVE or STUN (combos allowed):
  - sum = damage + hit_damage_in, computed at DMG_W+1 bits.
  - damage <= min(sum, MAX_DAMAGE).
  - len = BASE_HITSTUN + (new damage >> HITSTUN_SHIFT), saturated to 2**STUN_W-1; counter <= len.
  - state <= STUN; hit_accepted pulses the next cycle.
- got_hit in INVULN: ignored entirely; no damage change, no pulse.
- got_hit together with frame_tick: the hit loads the counter and there is no decrement that cycle.
- frame_tick with no higher-priority event:
  - STUN, counter > 1: decrement.
  - STUN, counter == 1: counter 0, state ACTIVE.
  - INVULN: same countdown, ending in ACTIVE.
  - ACTIVE: no change.
- Result: STUN lasts exactly len frame_ticks after the hit; INVULN lasts exactly RESPAWN_INVULN frame_ticks.
- Latency: every input takes effect on the following clock edge. hit_stun_active = (state==STUN); invuln_active = (state==INVULN).
- hit_damage_in == 0 with got_hit: still accepted; damage unchanged; hitstun is loaded.
- Reset mid-stun or mid-invuln: immediately returns to ACTIVE with damage 0.

Optional Feature:
- Macro HIT_TRACKER_POSTSTUN_INVULN_EN.
- Defined: adds parameter POSTSTUN_INVULN (default 10). A STUN expiry enters INVULN with counter <= POSTSTUN_INVULN instead of ACTIVE; if the parameter is 0, STUN expiry goes to ACTIVE.
- Undefined: STUN always expires to ACTIVE, and INVULN is reachable only via respawn.

Decomposition:
- Package hit_pkg: state enum (ACTIVE, STUN, INVULN) and default constants (MAX_DAMAGE, BASE_HITSTUN, HITSTUN_SHIFT, RESPAWN_INVULN).
- Sub-module hit_channel implements one player.
- hit_tracker instantiates NUM_PLAYERS channels with a generate loop and packs the port vectors.

Test Plan:
- Reset, then got_hit[0] with damage 12 -> damage[0]=12, hit_stun_active[0]=1 next cycle, hit_accepted[0] one cycle; stun drops after exactly 20 frame_ticks (20+(12>>4)=20); player 1 untouched.
- damage[0] preloaded to 100, hit 15 -> damage 115, stun 27 frames (20+7); a second hit of 5 at tick 10 -> damage 120, counter reloads to 27.
- damage 995, hit 12 -> damage saturates at 999; stun = 20+62 = 82 frames.
- respawn[1] -> damage[1]=0, invuln_active[1]=1 for 60 ticks; got_hit[1] during INVULN -> no change, no hit_accepted pulse.
- respawn and got_hit same cycle -> respawn wins; got_hit and frame_tick same cycle -> counter = len, no decrement; reset asserted mid-stun -> all outputs 0 next cycle.
- With HIT_TRACKER_POSTSTUN_INVULN_EN: after 20-frame stun -> invuln_active high for 10 ticks; hits in that window ignored.
